// File: rtl/ddr5_vr_mon_pkg.sv
// ============================================================================
// Module : ddr5_vr_mon_pkg
// Brief  : Shared types and constants for the DDR5 VR power-good monitor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ddr5_vr_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_PG = 2'd1,
    GOOD    = 2'd2,
    FAULT   = 2'd3
  } vr_state_e;

  localparam int DEF_DEBOUNCE_CNT  = 4;
  localparam int DEF_PWRUP_TIMEOUT = 20000;

  // True when a TMR_W-bit counter can reach the timeout value.
  function automatic bit tmr_w_ok(input int unsigned w, input int unsigned timeout);
    return (64'd1 << w) > 64'(timeout);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ddr5_pwrgd_ch_mon.sv
// ============================================================================
// Module : ddr5_pwrgd_ch_mon
// Brief  : One VR channel: 2-flop sync, debounce, power-up timer, channel FSM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ddr5_pwrgd_ch_mon
  import ddr5_vr_mon_pkg::*;
#(
  parameter int DEBOUNCE_CNT  = DEF_DEBOUNCE_CNT,
  parameter int PWRUP_TIMEOUT = DEF_PWRUP_TIMEOUT,
  parameter int TMR_W         = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_vr_ena,
  input  logic i_fault_clr,
  input  logic i_pwrgd_raw,
  output logic o_pwrgd,
  output logic o_fault,
  output logic o_timeout
);

  localparam logic [3:0]       C_DEB_LAST = 4'(DEBOUNCE_CNT);
  localparam logic [TMR_W-1:0] C_TMR_LAST = TMR_W'(PWRUP_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] C_TMR_MAX  = {TMR_W{1'b1}};

  logic             sync1_q, sync2_q;
  logic [3:0]       cnt_q, cnt_d;
  logic             filt_q, filt_d;
  logic [TMR_W-1:0] timer_q, timer_d, timer_inc;
  vr_state_e        state_q, state_d;
  logic             pwrgd_q, pwrgd_d;
  logic             fault_q, fault_d;
  logic             timeout_q, timeout_d;

  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (sync2_q == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q + 4'd1 == C_DEB_LAST) begin
      cnt_d  = '0;
      filt_d = sync2_q;
    end else begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // The FSM reacts to the filtered level in the cycle it flips.
  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    timer_inc = (timer_q == C_TMR_MAX) ? timer_q : timer_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (i_vr_ena && !fault_q) state_d = WAIT_PG;
      end
      WAIT_PG: begin
        if (!i_vr_ena) begin
          state_d = IDLE;
        end else if (filt_d) begin
          state_d = GOOD;
        end else if (timer_q == C_TMR_LAST) begin
          state_d   = FAULT;
          timeout_d = 1'b1;
        end
      end
      GOOD: begin
        if (!i_vr_ena) begin
          state_d = IDLE;
        end else if (!filt_d) begin
          state_d   = FAULT;
          timeout_d = 1'b0;
        end
      end
      FAULT: begin
        if (!i_vr_ena && i_fault_clr) begin
          state_d   = IDLE;
          timeout_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    timer_d = (state_q == WAIT_PG && state_d == WAIT_PG) ? timer_inc : '0;
    pwrgd_d = (state_d == GOOD);
    fault_d = (state_d == FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      cnt_q     <= '0;
      filt_q    <= 1'b0;
      timer_q   <= '0;
      state_q   <= IDLE;
      pwrgd_q   <= 1'b0;
      fault_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      sync1_q   <= i_pwrgd_raw;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      filt_q    <= filt_d;
      timer_q   <= timer_d;
      state_q   <= state_d;
      pwrgd_q   <= pwrgd_d;
      fault_q   <= fault_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_pwrgd   = pwrgd_q;
  assign o_fault   = fault_q;
  assign o_timeout = timeout_q;

endmodule

`default_nettype wire

// File: rtl/ddr5_vr_pwrgd_monitor.sv
// ============================================================================
// Module : ddr5_vr_pwrgd_monitor
// Brief  : Per-MC DRAMPWRGD_DDRIO VR monitor with aggregated fail indication.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ddr5_vr_pwrgd_monitor
  import ddr5_vr_mon_pkg::*;
#(
  parameter int MC_SIZE       = 4,
  parameter int DEBOUNCE_CNT  = DEF_DEBOUNCE_CNT,
  parameter int PWRUP_TIMEOUT = DEF_PWRUP_TIMEOUT,
  parameter int TMR_W         = 15
) (
  input  logic               iClk,
  input  logic               iRst_n,
  input  logic               iVrEna,
  input  logic               iFaultClr,
  input  logic [MC_SIZE-1:0] iDramPwrgdRaw,
  output logic [MC_SIZE-1:0] oDramPwrgdDDRIO,
  output logic               oMemPwrGdFail,
  output logic [MC_SIZE-1:0] oChFault,
  output logic [MC_SIZE-1:0] oChTimeout,
  output logic               oAllPwrgd
);

  generate
    if (!tmr_w_ok(TMR_W, PWRUP_TIMEOUT)) begin : g_tmr_w_bad
      $error("TMR_W too narrow for PWRUP_TIMEOUT");
    end
  endgenerate

  logic [MC_SIZE-1:0] ch_pwrgd, ch_fault, ch_timeout;
  logic               fail_q, fail_d;
  logic               all_q, all_d;

  generate
    for (genvar i = 0; i < MC_SIZE; i++) begin : g_ch
      ddr5_pwrgd_ch_mon #(
        .DEBOUNCE_CNT  (DEBOUNCE_CNT),
        .PWRUP_TIMEOUT (PWRUP_TIMEOUT),
        .TMR_W         (TMR_W)
      ) u_ch (
        .clk         (iClk),
        .rst_n       (iRst_n),
        .i_vr_ena    (iVrEna),
        .i_fault_clr (iFaultClr),
        .i_pwrgd_raw (iDramPwrgdRaw[i]),
        .o_pwrgd     (ch_pwrgd[i]),
        .o_fault     (ch_fault[i]),
        .o_timeout   (ch_timeout[i])
      );
    end
  endgenerate

  always_comb begin
    fail_d = |ch_fault;
    all_d  = &ch_pwrgd;
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      fail_q <= 1'b0;
      all_q  <= 1'b0;
    end else begin
      fail_q <= fail_d;
      all_q  <= all_d;
    end
  end

  assign oDramPwrgdDDRIO = ch_pwrgd;
  assign oChFault        = ch_fault;
  assign oChTimeout      = ch_timeout;
  assign oMemPwrGdFail   = fail_q;
  assign oAllPwrgd       = all_q;

endmodule

`default_nettype wire

// File: doc/ddr5_vr_pwrgd_monitor.md
Name: ddr5_vr_pwrgd_monitor

Overview:
- Per-memory-controller DRAMPWRGD_DDRIO VR monitor that sits directly upstream of ddr5_top.
- Synchronizes and debounces each raw VR power-good, supervises VR power-up against a timeout, and detects VR drop-out while enabled.
- Produces the filtered per-MC power-good vector (feeds iDramPwrgdDDRIO) and the aggregated, registered iMemPwrGdFail.
- Latched per-channel fault status is exposed to the master sequencer.

Parameters:
- MC_SIZE, 4, number of memory-controller VR channels.
- DEBOUNCE_CNT, 4, consecutive identical synchronized samples needed to change a filtered output (1..15).
- PWRUP_TIMEOUT, 20000, iClk cycles (10 ms at 2 MHz) allowed from enable to filtered power-good.
- TMR_W, 15, timeout counter width; must satisfy 2^TMR_W > PWRUP_TIMEOUT.

Ports:
- iClk  input  1  2 MHz system clock.
- iRst_n  input  1  asynchronous active-low reset.
- iVrEna  input  1  master sequencer has enabled the memory VRs; level.
- iFaultClr  input  1  clears latched faults; honoured only while iVrEna=0.
- iDramPwrgdRaw  input  MC_SIZE  raw asynchronous VR power-good pins.
- oDramPwrgdDDRIO  output  MC_SIZE  filtered power-good, qualified by state GOOD.
- oMemPwrGdFail  output  1  OR of all channel faults, registered.
- oChFault  output  MC_SIZE  latched per-channel fault.
- oChTimeout  output  MC_SIZE  fault cause: 1 = power-up timeout, 0 = drop-out.
- oAllPwrgd  output  1  all channels in GOOD.

Behaviour:
- Reset: all outputs 0; sync flops 0; debounce counters 0; filtered levels 0; timers 0; every channel FSM in IDLE.
- Synchronizer: 2-flop per bit. Debounce: counter increments while the sync sample differs from the filtered level. Filtered level flips when the count reaches DEBOUNCE_CNT; the counter resets to 0 on any matching sample. Raw-to-filtered latency is 2 + DEBOUNCE_CNT cycles.
- Channel FSM (one per MC):
  - IDLE: timer=0. Go to WAIT_PG when iVrEna=1 and fault=0.
  - WAIT_PG: timer increments each cycle.
    - Filtered=1 -> GOOD.
    - timer == PWRUP_TIMEOUT-1 with filtered still 0 -> FAULT, set timeout cause=1.
    - iVrEna=0 -> IDLE.
  - GOOD: filtered=0 while iVrEna=1 -> FAULT, cause=0. iVrEna=0 -> IDLE, with no fault (orderly shutdown).
  - FAULT: stays until iVrEna=0 and iFaultClr=1, then -> IDLE and fault and cause clear. A fault is not cleared by iVrEna=0 alone.
- Output timing:
  - oDramPwrgdDDRIO[i] = registered (state==GOOD); it drops in the same cycle the FSM leaves GOOD.
  - oChFault[i] is set on the FAULT transition edge.
  - oMemPwrGdFail asserts 1 cycle after any oChFault bit, and is held while any fault is latched.
- Simultaneous events:
  - Timeout expiry and filtered rise in the same cycle: GOOD wins.
  - Filtered drop in GOOD and iVrEna fall in the same cycle: IDLE, no fault.
  - iFaultClr with iVrEna=1: ignored.
- Timer saturates; it never wraps.
- Reset asserted mid-operation: immediate return to reset values, no fault retained.
- Channels are fully independent; one faulted channel does not alter the others' FSMs.

Decomposition:
- Shared package ddr5_vr_mon_pkg holds:
  - state enum IDLE=2'd0, WAIT_PG=2'd1, GOOD=2'd2, FAULT=2'd3;
  - default constants DEBOUNCE_CNT and PWRUP_TIMEOUT;
  - a function for the timer-width check.
- Sub-module ddr5_pwrgd_ch_mon covers one channel (synchronizer, debounce, timer, FSM). The top generates MC_SIZE instances and registers the fault OR plus the AND of the GOOD flags.

Test Plan:
- Power-up: iVrEna=1, raw[3:0] rise at cycle 100 -> oDramPwrgdDDRIO=4'hF at cycle 106, oAllPwrgd=1, oMemPwrGdFail=0.
- Glitch reject: in GOOD, raw[1]=0 for 3 cycles -> no change. Raw[1]=0 for 4 cycles -> oDramPwrgdDDRIO[1]=0, oChFault=4'b0010, oChTimeout[1]=0, oMemPwrGdFail=1 one cycle later.
- Timeout: iVrEna=1, raw[2] held 0 -> oChFault[2]=1 and oChTimeout[2]=1 at cycle 20000 after enable; other channels GOOD.
- Orderly shutdown: iVrEna=0, then raw falls -> no faults, all outputs return to 0.
- Fault clear: iFaultClr=1 with iVrEna=1 -> fault held. iVrEna=0 then iFaultClr=1 -> oChFault=0, oMemPwrGdFail=0 next cycle; re-enable powers up normally.
- Async reset: pulse iRst_n low mid-WAIT_PG and again in FAULT -> all outputs 0 immediately, restart from IDLE.
